mem_arbiter: RTL and testbench

//  Shares one multi-cycle, single-port memory between the fetch stage (read-only) and the memory stage (read/write).

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/arb_timeout_ctr.sv | 29 ++
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified-memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF  = 16;
    localparam int unsigned DATA_W_DEF  = 16;
    localparam int unsigned TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Counts BUSY cycles; expired flags the last cycle the arbiter will wait for mem_done.
module arb_timeout_ctr #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // cnt_q holds the number of BUSY cycles already completed.
    assign expired = enable && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Serializes fetch reads and data reads/writes onto one multi-cycle memory port,
// with round-robin tie-break, hung-memory timeout and illegal-request detection.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    output logic              i_stall,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_stall,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              err
);

    state_e state_q, state_d;
    owner_e owner_q, owner_d, last_grant_q, last_grant_d, grant;
    op_e    op_q, op_d;

    logic              any_req, illegal, expired, finish;
    logic              mem_rd_d, mem_wr_d, i_done_d, d_done_d, err_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d, i_rdata_d, d_rdata_d, ret_data;

    // Grant: sole requester wins; on a tie the one not served last wins.
    always_comb begin
        any_req = i_req | d_rd | d_wr;
        if (i_req && (d_rd || d_wr)) begin
            grant = (last_grant_q == OWN_I) ? OWN_D : OWN_I;
        end else begin
            grant = (d_rd || d_wr) ? OWN_D : OWN_I;
        end
        illegal  = (grant == OWN_D) && d_rd && d_wr;
        finish   = mem_done || expired;
        ret_data = mem_done ? mem_rdata : '0;
    end

    arb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst_n   (rst),
        .clear   (state_q == IDLE),
        .enable  (state_q == BUSY),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = illegal ? DONE : BUSY;
            BUSY:    if (finish) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for every registered output and the per-access latches.
    always_comb begin
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        addr_d       = mem_addr;
        wdata_d      = mem_wdata;
        i_rdata_d    = i_rdata;
        d_rdata_d    = d_rdata;
        err_d        = err;
        mem_rd_d     = 1'b0;
        mem_wr_d     = 1'b0;
        i_done_d     = 1'b0;
        d_done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d      = grant;
                    last_grant_d = grant;
                    if (illegal) begin
                        err_d     = 1'b1;
                        d_done_d  = 1'b1;
                        d_rdata_d = '0;
                    end else if (grant == OWN_D) begin
                        addr_d   = d_addr;
                        wdata_d  = d_wdata;
                        op_d     = d_wr ? OP_WR : OP_RD;
                        mem_rd_d = ~d_wr;
                        mem_wr_d = d_wr;
                    end else begin
                        addr_d   = i_addr;
                        op_d     = OP_RD;
                        mem_rd_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (finish) begin
                    if (owner_q == OWN_I) i_done_d = 1'b1;
                    else                  d_done_d = 1'b1;
                    if (!mem_done) err_d = 1'b1;
                    // Completed writes keep the old read data; timeouts return zero.
                    if (!mem_done || op_q == OP_RD) begin
                        if (owner_q == OWN_I) i_rdata_d = ret_data;
                        else                  d_rdata_d = ret_data;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q      <= OWN_I;
            last_grant_q <= OWN_I;
            op_q         <= OP_RD;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            i_rdata      <= '0;
            d_rdata      <= '0;
            err          <= 1'b0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            i_done       <= 1'b0;
            d_done       <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            mem_addr     <= addr_d;
            mem_wdata    <= wdata_d;
            i_rdata      <= i_rdata_d;
            d_rdata      <= d_rdata_d;
            err          <= err_d;
            mem_rd       <= mem_rd_d;
            mem_wr       <= mem_wr_d;
            i_done       <= i_done_d;
            d_done       <= d_done_d;
        end
    end

    assign i_stall = i_req & ~i_done;
    assign d_stall = (d_rd | d_wr) & ~d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant order, latency, write path, timeout, illegal request, async reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_rd, d_wr, mem_done;
    logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        i_done, i_stall, d_done, d_stall, mem_rd, mem_wr, err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_done    (i_done),
        .i_stall   (i_stall),
        .d_rd      (d_rd),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .d_stall   (d_stall),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req = 0; d_rd = 0; d_wr = 0; mem_done = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    endtask

    initial begin
        logic early;
        rst = 1'b0;
        idle_inputs();

        // 1: outputs stay zero under random inputs while in reset
        for (int n = 0; n < 4; n++) begin
            i_req = 1'($urandom); d_rd = 1'($urandom); d_wr = 1'($urandom);
            mem_done = 1'($urandom); mem_rdata = 16'($urandom);
            i_addr = 16'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
            tick();
            chk("rst_flags", {27'd0, mem_rd, mem_wr, i_done, d_done, err}, 32'd0);
            chk("rst_data", {mem_addr, mem_wdata}, 32'd0);
            chk("rst_rdata", {i_rdata, d_rdata}, 32'd0);
        end
        idle_inputs();
        rst = 1'b1;
        i_req = 1; i_addr = 16'h0010;
        tick();
        chk("t1_mem_rd", mem_rd, 1);
        chk("t1_mem_addr", mem_addr, 16'h0010);
        chk("t1_stall", i_stall, 1);
        tick();
        chk("t1_strobe_1cyc", mem_rd, 0);
        tick();
        mem_done = 1; mem_rdata = 16'h1234;
        tick();
        mem_done = 0;
        chk("t1_i_done", i_done, 1);
        chk("t1_i_rdata", i_rdata, 16'h1234);
        chk("t1_stall_off", i_stall, 0);
        i_req = 0;
        tick();
        chk("t1_done_pulse", i_done, 0);
        chk("t1_rdata_hold", i_rdata, 16'h1234);

        // 2: tie with last_grant=I -> D first, then I after one bubble
        i_req = 1; i_addr = 16'h0100; d_rd = 1; d_addr = 16'h0200;
        tick();
        chk("t2_d_first", {mem_rd, mem_addr}, {1'b1, 16'h0200});
        chk("t2_stalls", {i_stall, d_stall}, 2'b11);
        mem_done = 1; mem_rdata = 16'hAAAA;
        tick();
        mem_done = 0;
        chk("t2_d_done", {i_done, d_done}, 2'b01);
        chk("t2_d_rdata", d_rdata, 16'hAAAA);
        chk("t2_i_stall", i_stall, 1);
        d_rd = 0;
        tick();
        chk("t2_bubble", {mem_rd, i_stall}, 2'b01);
        tick();
        chk("t2_i_grant", {mem_rd, mem_addr}, {1'b1, 16'h0100});
        mem_done = 1; mem_rdata = 16'h5555;
        tick();
        mem_done = 0;
        chk("t2_i_done", {i_done, d_done}, 2'b10);
        chk("t2_i_rdata", i_rdata, 16'h5555);
        chk("t2_d_rdata_hold", d_rdata, 16'hAAAA);
        i_req = 0;
        tick();

        // 3: write
        d_wr = 1; d_addr = 16'h0F00; d_wdata = 16'hBEEF;
        tick();
        chk("t3_strobes", {mem_rd, mem_wr}, 2'b01);
        chk("t3_addr", mem_addr, 16'h0F00);
        chk("t3_wdata", mem_wdata, 16'hBEEF);
        tick();
        chk("t3_wr_1cyc", mem_wr, 0);
        mem_done = 1; mem_rdata = 16'h9999;
        tick();
        mem_done = 0;
        chk("t3_d_done", d_done, 1);
        chk("t3_rdata_kept", d_rdata, 16'hAAAA);
        chk("t3_no_err", err, 0);
        d_wr = 0;
        tick();

        // 4: timeout after 15 BUSY cycles
        d_rd = 1; d_addr = 16'h0300;
        early = 0;
        for (int n = 0; n < 15; n++) begin
            tick();
            if (d_done || err) early = 1;
        end
        chk("t4_not_early", early, 0);
        tick();
        chk("t4_d_done", d_done, 1);
        chk("t4_rdata_zero", d_rdata, 16'h0000);
        chk("t4_err", err, 1);
        d_rd = 0;
        repeat (3) tick();
        chk("t4_err_sticky", err, 1);

        // 5: illegal request after a fresh reset
        rst = 1'b0;
        #2;
        chk("t5_err_cleared", err, 0);
        tick();
        rst = 1'b1;
        d_rd = 1; d_wr = 1; d_addr = 16'h0444;
        tick();
        chk("t5_d_done", d_done, 1);
        chk("t5_no_strobe", {mem_rd, mem_wr}, 2'b00);
        chk("t5_err", err, 1);
        chk("t5_rdata", d_rdata, 16'h0000);
        d_rd = 0; d_wr = 0;
        tick();
        chk("t5_after", {mem_rd, mem_wr, d_done}, 3'b000);

        // 6: async reset mid-BUSY, then a normal access
        i_req = 1; i_addr = 16'h0400;
        tick();
        chk("t6_mem_rd", mem_rd, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async_drop", {mem_rd, mem_wr, i_done, d_done, err}, 5'b0);
        tick();
        rst = 1'b1;
        tick();
        chk("t6_restart", {mem_rd, mem_addr}, {1'b1, 16'h0400});
        mem_done = 1; mem_rdata = 16'hC0DE;
        tick();
        mem_done = 0;
        chk("t6_i_done", i_done, 1);
        chk("t6_i_rdata", i_rdata, 16'hC0DE);
        chk("t6_err_clear", err, 0);
        i_req = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
